// File: rtl/life_bars.sv
// life_bars: per-player life bar overlay with ghost trail and low-life blink.
// Pixel path is two registered stages: region compare, then colour select.
module life_bars #(
  parameter int NPLAYERS     = 2,
  parameter int LIFE_W       = 7,
  parameter int LIFE_MAX     = 100,
  parameter int BAR_Y        = 554,
  parameter int BAR_H        = 15,
  parameter int ROW_PITCH    = 24,
  parameter int MARGIN       = 10,
  parameter int SCREEN_W     = 800,
  parameter int LOW_THR      = 50,
  parameter int BLINK_THR    = 20,
  parameter int BLINK_FRAMES = 16,
  parameter int GHOST_DELAY  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [10:0]         spotX,
  input  logic signed [10:0]         spotY,
  input  logic                       frame_start,
  input  logic [NPLAYERS*LIFE_W-1:0] life,
  output logic [23:0]                life_rgb
);

  localparam int HW = $clog2(GHOST_DELAY + 1);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [LIFE_W-1:0] LMAX  = LIFE_W'(LIFE_MAX);
  localparam logic [HW-1:0]     HMAX  = HW'(GHOST_DELAY);
  localparam logic [FW-1:0]     FLAST = FW'(BLINK_FRAMES - 1);

  localparam logic [23:0] C_NONE = 24'hFFFFFF;
  localparam logic [23:0] C_S0   = 24'hC1BFB1;
  localparam logic [23:0] C_S1   = 24'hCECECE;
  localparam logic [23:0] C_S2   = 24'hE6E6E6;
  localparam logic [23:0] C_GRN  = 24'h149414;
  localparam logic [23:0] C_RED  = 24'hEE1010;
  localparam logic [23:0] C_GHO  = 24'hF0D020;

  // Per-frame state
  logic [LIFE_W-1:0] lc   [NPLAYERS];
  logic [LIFE_W-1:0] l_q  [NPLAYERS];
  logic [LIFE_W-1:0] l_d  [NPLAYERS];
  logic [LIFE_W-1:0] g_q  [NPLAYERS];
  logic [LIFE_W-1:0] g_d  [NPLAYERS];
  logic [HW-1:0]     h_q  [NPLAYERS];
  logic [HW-1:0]     h_d  [NPLAYERS];
  logic [FW-1:0]     fcnt_q;
  logic [FW-1:0]     fcnt_d;
  logic              phase_q;
  logic              phase_d;

  // Stage 1: per-player region hits
  logic [NPLAYERS-1:0] fill_d;
  logic [NPLAYERS-1:0] fill_q;
  logic [NPLAYERS-1:0] ghost_d;
  logic [NPLAYERS-1:0] ghost_q;
  logic [NPLAYERS-1:0] sup_d;
  logic [NPLAYERS-1:0] sup_q;
  logic [NPLAYERS-1:0] red_d;
  logic [NPLAYERS-1:0] red_q;
  logic [1:0]          shade_d [NPLAYERS];
  logic [1:0]          shade_q [NPLAYERS];

  // Stage 2: final colour
  logic [23:0] rgb_d;
  logic [23:0] rgb_q;

  // Geometry scratch, all signed 32-bit so no compare can wrap
  logic signed [31:0] sx;
  logic signed [31:0] sy;
  logic signed [31:0] xp;
  logic signed [31:0] ry;
  logic signed [31:0] lv;
  logic signed [31:0] gv;
  logic               on_scr;
  logic               rows_fill;
  logic               blink;

  // Latch clamped life and advance the ghost trail once per frame
  always_comb begin
    for (int p = 0; p < NPLAYERS; p++) begin
      lc[p] = life[p*LIFE_W +: LIFE_W];
      if (lc[p] > LMAX) begin
        lc[p] = LMAX;
      end
      l_d[p] = l_q[p];
      g_d[p] = g_q[p];
      h_d[p] = h_q[p];
      if (frame_start) begin
        l_d[p] = lc[p];
        if (lc[p] >= g_q[p]) begin
          g_d[p] = lc[p];
          h_d[p] = '0;
        end else if (lc[p] < l_q[p]) begin
          h_d[p] = '0;
        end else if (h_q[p] < HMAX) begin
          h_d[p] = h_q[p] + HW'(1);
        end else begin
          g_d[p] = g_q[p] - LIFE_W'(1);
        end
      end
    end
  end

  // Blink frame counter; phase flips every BLINK_FRAMES frames
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (fcnt_q == FLAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Frame state registers; reset wins over a coincident frame_start
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NPLAYERS; p++) begin
        l_q[p] <= '0;
        g_q[p] <= '0;
        h_q[p] <= '0;
      end
      fcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      for (int p = 0; p < NPLAYERS; p++) begin
        l_q[p] <= l_d[p];
        g_q[p] <= g_d[p];
        h_q[p] <= h_d[p];
      end
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  // Region compare for every player against the latched life values
  always_comb begin
    sx        = {{21{spotX[10]}}, spotX};
    sy        = {{21{spotY[10]}}, spotY};
    on_scr    = (sx >= 0) && (sy >= 0);
    xp        = '0;
    ry        = '0;
    lv        = '0;
    gv        = '0;
    rows_fill = 1'b0;
    blink     = 1'b0;
    fill_d    = '0;
    ghost_d   = '0;
    sup_d     = '0;
    red_d     = '0;
    for (int p = 0; p < NPLAYERS; p++) begin
      shade_d[p] = 2'd0;
      xp = (p % 2 == 0) ? sx : (SCREEN_W - 1 - sx);
      ry = BAR_Y + (p >> 1) * ROW_PITCH;
      lv = 32'(l_q[p]);
      gv = 32'(g_q[p]);
      rows_fill = (sy >= ry) && (sy <= ry + BAR_H - 2);
      blink = (lv != 0) && (lv < BLINK_THR) && !phase_q;
      if (on_scr) begin
        if (xp >= MARGIN && xp <= MARGIN + 2 &&
            sy >= ry && sy <= ry + BAR_H - 1) begin
          sup_d[p]   = 1'b1;
          shade_d[p] = 2'(xp - MARGIN);
        end else if (xp >= MARGIN &&
                     xp <= MARGIN + LIFE_MAX + 4 &&
                     sy >= ry + BAR_H &&
                     sy <= ry + BAR_H + 2) begin
          sup_d[p]   = 1'b1;
          shade_d[p] = 2'(sy - ry - BAR_H);
        end
        fill_d[p] = rows_fill && !blink &&
                    xp >= MARGIN + 4 &&
                    xp <= MARGIN + 3 + lv;
        ghost_d[p] = rows_fill &&
                     xp >= MARGIN + 4 + lv &&
                     xp <= MARGIN + 3 + gv;
      end
      red_d[p] = lv < LOW_THR;
    end
  end

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q  <= '0;
      ghost_q <= '0;
      sup_q   <= '0;
      red_q   <= '0;
      for (int p = 0; p < NPLAYERS; p++) begin
        shade_q[p] <= 2'd0;
      end
    end else begin
      fill_q  <= fill_d;
      ghost_q <= ghost_d;
      sup_q   <= sup_d;
      red_q   <= red_d;
      for (int p = 0; p < NPLAYERS; p++) begin
        shade_q[p] <= shade_d[p];
      end
    end
  end

  // Colour select: lowest hit player wins, then fill > ghost > support
  always_comb begin
    rgb_d = C_NONE;
    for (int p = NPLAYERS - 1; p >= 0; p--) begin
      if (fill_q[p]) begin
        rgb_d = red_q[p] ? C_RED : C_GRN;
      end else if (ghost_q[p]) begin
        rgb_d = C_GHO;
      end else if (sup_q[p]) begin
        case (shade_q[p])
          2'd0:    rgb_d = C_S0;
          2'd1:    rgb_d = C_S1;
          default: rgb_d = C_S2;
        endcase
      end
    end
  end

  // Stage 2 register drives the output pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= C_NONE;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign life_rgb = rgb_q;

endmodule
